// File: rtl/servo_ramp_controller.sv
// Multi-channel hobby-servo PWM generator with per-frame slew-limited width updates.
// Define SERVO_RAMP_EN for slew-limited stepping; otherwise live width jumps to target each frame.
module servo_ramp_controller #(
    parameter  int NUM_CH    = 2,
    parameter  int CLK_HZ    = 50000000,
    parameter  int PERIOD_US = 20000,
    parameter  int MIN_US    = 1000,
    parameter  int MAX_US    = 2000,
    parameter  int CENTER_US = 1500,
    parameter  int STEP_US   = 20,
    parameter  int W         = 15,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CW-1:0]     cmd_ch,
    input  logic [W-1:0]      cmd_width,
    output logic              cmd_err,
    output logic [NUM_CH-1:0] servo,
    output logic [NUM_CH-1:0] at_target,
    output logic              frame_start
);

`ifdef SERVO_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    localparam int              DIV       = CLK_HZ / 1000000;
    localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PSC_LAST  = PW'(DIV - 1);
    localparam logic [W-1:0]    FCNT_LAST = W'(PERIOD_US - 1);
    localparam logic [W-1:0]    MIN_W     = W'(MIN_US);
    localparam logic [W-1:0]    MAX_W     = W'(MAX_US);
    localparam logic [W-1:0]    CENTER_W  = W'(CENTER_US);
    localparam logic [CW:0]     NUM_CH_W  = (CW + 1)'(NUM_CH);
    // A full-range step makes the slew limiter collapse to a direct live <= target copy.
    localparam logic [W:0]      STEP_W    = RAMP_EN ? (W + 1)'(STEP_US) : {1'b0, {W{1'b1}}};

    logic [PW-1:0]     psc_q, psc_d;
    logic [W-1:0]      fcnt_q, fcnt_d;
    logic [W-1:0]      target_q [NUM_CH];
    logic [W-1:0]      target_d [NUM_CH];
    logic [W-1:0]      live_q   [NUM_CH];
    logic [W-1:0]      live_d   [NUM_CH];
    logic [NUM_CH-1:0] servo_q, servo_d;
    logic [NUM_CH-1:0] at_target_q, at_target_d;
    logic              cmd_err_q, cmd_err_d;
    logic              frame_start_q, frame_start_d;

    logic              us_tick;
    logic              boundary;
    logic              accept;
    logic              ch_ok;
    logic [W-1:0]      clamped;

    function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic [W:0] up;
        logic [W:0] lim;
        up  = {1'b0, cur} + STEP_W;
        lim = {1'b0, tgt} + STEP_W;
        if (cur < tgt) begin
            return (up >= {1'b0, tgt}) ? tgt : up[W-1:0];
        end else if (cur > tgt) begin
            return ({1'b0, cur} <= lim) ? tgt : W'({1'b0, cur} - STEP_W);
        end
        return cur;
    endfunction

    always_comb begin
        us_tick  = (psc_q == PSC_LAST);
        boundary = us_tick && (fcnt_q == FCNT_LAST);
        accept   = cmd_valid && !boundary;
        ch_ok    = ({1'b0, cmd_ch} < NUM_CH_W);

        if (cmd_width < MIN_W) begin
            clamped = MIN_W;
        end else if (cmd_width > MAX_W) begin
            clamped = MAX_W;
        end else begin
            clamped = cmd_width;
        end

        psc_d  = us_tick ? '0 : psc_q + PW'(1);
        fcnt_d = fcnt_q;
        if (us_tick) begin
            fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + W'(1);
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            target_d[i] = target_q[i];
            if (accept && ch_ok && (CW'(i) == cmd_ch)) begin
                target_d[i] = clamped;
            end
            live_d[i]      = boundary ? step_toward(live_q[i], target_q[i]) : live_q[i];
            servo_d[i]     = (fcnt_q < live_q[i]) && enable;
            at_target_d[i] = (live_q[i] == target_q[i]);
        end

        cmd_err_d     = accept && !ch_ok;
        frame_start_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q         <= '0;
            fcnt_q        <= '0;
            servo_q       <= '0;
            at_target_q   <= '1;
            cmd_err_q     <= 1'b0;
            frame_start_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                target_q[i] <= CENTER_W;
                live_q[i]   <= CENTER_W;
            end
        end else begin
            psc_q         <= psc_d;
            fcnt_q        <= fcnt_d;
            servo_q       <= servo_d;
            at_target_q   <= at_target_d;
            cmd_err_q     <= cmd_err_d;
            frame_start_q <= frame_start_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                target_q[i] <= target_d[i];
                live_q[i]   <= live_d[i];
            end
        end
    end

    assign cmd_ready   = !boundary;
    assign cmd_err     = cmd_err_q;
    assign servo       = servo_q;
    assign at_target   = at_target_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_ramp_controller.sv
// Self-checking bench for servo_ramp_controller: directed steps plus random commands against a frame-level model.
module tb_servo_ramp_controller;

    // Three channels so that cmd_ch = 3 is representable and out of range.
    localparam int NCH    = 3;
    localparam int CW     = 2;
    localparam int W      = 8;
    localparam int DIV    = 4;
    localparam int PERIOD = 100;
    localparam int MIN    = 10;
    localparam int MAX    = 90;
    localparam int CENTER = 50;
    localparam int STEP   = 8;
    localparam int FRAME  = DIV * PERIOD;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           cmd_valid = 1'b0;
    logic [CW-1:0]  cmd_ch = '0;
    logic [W-1:0]   cmd_width = '0;
    logic           cmd_ready;
    logic           cmd_err;
    logic           frame_start;
    logic [NCH-1:0] servo;
    logic [NCH-1:0] at_target;

    int tests = 0;
    int failed = 0;

    int m_live [NCH];
    int m_tgt  [NCH];
    int hi_cnt [NCH];

    typedef struct {
        int ch;
        int width;
    } cmd_t;
    cmd_t pend[$];
    bit late_cmd = 1'b0;
    bit en_glitch = 1'b0;

    always #5 clk = ~clk;

    servo_ramp_controller #(
        .NUM_CH   (NCH),
        .CLK_HZ   (4000000),
        .PERIOD_US(PERIOD),
        .MIN_US   (MIN),
        .MAX_US   (MAX),
        .CENTER_US(CENTER),
        .STEP_US  (STEP),
        .W        (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_width  (cmd_width),
        .cmd_err    (cmd_err),
        .servo      (servo),
        .at_target  (at_target),
        .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampw(input int w);
        if (w < MIN) return MIN;
        if (w > MAX) return MAX;
        return w;
    endfunction

    // Reference slew rule: move toward target by at most STEP per frame (or jump when unramped).
    function automatic int model_step(input int live, input int tgt);
`ifdef SERVO_RAMP_EN
        if (tgt > live + STEP) return live + STEP;
        if (tgt < live - STEP) return live - STEP;
`endif
        return tgt;
    endfunction

    function automatic logic [NCH-1:0] eq_bits();
        logic [NCH-1:0] b;
        for (int k = 0; k < NCH; k++) b[k] = (m_live[k] == m_tgt[k]);
        return b;
    endfunction

    function automatic logic [NCH-1:0] high_bits(input int us);
        logic [NCH-1:0] b;
        for (int k = 0; k < NCH; k++) b[k] = (us < m_live[k]);
        return b;
    endfunction

    task automatic wait_fs();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            @(negedge clk);
            seen = frame_start;
        end
        chk("frame_start_seen", 32'(seen), 1);
    endtask

    task automatic measure();
        for (int k = 0; k < NCH; k++) hi_cnt[k] = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) chk("frame_start_one_cycle", 32'(frame_start), 0);
            for (int k = 0; k < NCH; k++) if (servo[k]) hi_cnt[k]++;
        end
    endtask

    task automatic drive();
        cmd_t c;
        if (late_cmd) begin
            repeat (FRAME - 2) @(negedge clk);
            chk("ready_before_boundary", 32'(cmd_ready), 1);
            @(negedge clk);
            chk("ready_at_boundary", 32'(cmd_ready), 0);
            c = pend[0];
            cmd_valid = 1'b1;
            cmd_ch    = CW'(c.ch);
            cmd_width = W'(c.width);
        end else if (en_glitch) begin
            repeat (20) @(negedge clk);
            chk("servo_before_drop", 32'(servo), 32'(high_bits(4)));
            enable = 1'b0;
            @(negedge clk);
            chk("servo_drop", 32'(servo), 0);
            repeat (9) @(negedge clk);
            enable = 1'b1;
            @(negedge clk);
            chk("servo_reassert", 32'(servo), 32'(high_bits(7)));
        end else begin
            while (pend.size() > 0) begin
                c = pend.pop_front();
                cmd_valid = 1'b1;
                cmd_ch    = CW'(c.ch);
                cmd_width = W'(c.width);
                chk("cmd_ready", 32'(cmd_ready), 1);
                @(negedge clk);
                chk("cmd_err", 32'(cmd_err), 32'(c.ch >= NCH));
                if (c.ch < NCH) m_tgt[c.ch] = clampw(c.width);
            end
            cmd_valid = 1'b0;
        end
    endtask

    task automatic frame_step(input string tag);
        int exp_hi;
        wait_fs();
        fork
            measure();
            drive();
        join
        for (int k = 0; k < NCH; k++) begin
            exp_hi = DIV * m_live[k] - (en_glitch ? 10 : 0);
            chk($sformatf("%s_high_ch%0d", tag, k), 32'(hi_cnt[k]), 32'(exp_hi));
        end
        chk($sformatf("%s_at_target", tag), 32'(at_target), 32'(eq_bits()));
        for (int k = 0; k < NCH; k++) m_live[k] = model_step(m_live[k], m_tgt[k]);
    endtask

    task automatic push(input int ch, input int width);
        cmd_t c;
        c.ch = ch;
        c.width = width;
        pend.push_back(c);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_live[k] = CENTER;
            m_tgt[k]  = CENTER;
        end
    endtask

    initial begin
        model_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_servo", 32'(servo), 0);
        chk("reset_cmd_err", 32'(cmd_err), 0);
        chk("reset_frame_start", 32'(frame_start), 0);
        chk("reset_at_target", 32'(at_target), 32'({NCH{1'b1}}));

        rst_n = 1'b1;
        @(negedge clk);
        chk("first_rise", 32'(servo), 32'({NCH{1'b1}}));
        chk("ready_after_reset", 32'(cmd_ready), 1);

        frame_step("idle");

        push(0, 90);
        frame_step("cmd_ch0");
        repeat (6) frame_step("ramp_ch0");

        push(1, 5);
        push(1, 200);
        repeat (6) frame_step("ch1_clamp");

        push(3, 40);
        push(0, 10);
        frame_step("bad_ch");

        late_cmd = 1'b1;
        push(1, 30);
        frame_step("late_hold");
        late_cmd = 1'b0;
        repeat (3) frame_step("late_take");

        en_glitch = 1'b1;
        frame_step("enable_drop");
        en_glitch = 1'b0;

        for (int f = 0; f < 12; f++) begin
            int n;
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) push(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            frame_step($sformatf("rand%0d", f));
        end

        push(0, 90);
        push(2, 10);
        frame_step("pre_reset");
        frame_step("mid_ramp");
        @(negedge clk);
        repeat (10) @(negedge clk);
        chk("servo_before_reset", 32'(servo), 32'(high_bits(2)));
        rst_n = 1'b0;
        #1;
        chk("async_reset_servo", 32'(servo), 0);
        chk("async_reset_at_target", 32'(at_target), 32'({NCH{1'b1}}));
        chk("async_reset_frame_start", 32'(frame_start), 0);
        chk("async_reset_cmd_err", 32'(cmd_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        frame_step("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
